// File: rtl/exp_sched_pkg.sv
// exp_sched_pkg: shared types and constants for the exp engine scheduler
// Contents: sched_state_t FSM encoding, default engine operand width and
// fractional bits, and the positive saturation value returned on timeout.
package exp_sched_pkg;
  localparam int EXP_DATA_WIDTH = 16;
  localparam int EXP_FIXED_PNT = 8;
  localparam logic [EXP_DATA_WIDTH-1:0] EXP_SAT_POS = {1'b0, {(EXP_DATA_WIDTH-1){1'b1}}};
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, GAP} sched_state_t;
endpackage

// File: rtl/exp_sched_rr_pick.sv
// exp_sched_rr_pick: combinational round-robin pick starting at ptr_i
// Ports: req_i (request vector), ptr_i (search start index),
//        grant_valid_o (any request), grant_idx_o (winning index).
module exp_sched_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic             grant_valid_o,
  output logic [IW-1:0]    grant_idx_o
);
  logic [2*N_REQ-1:0] masked;
  assign grant_valid_o = |req_i;
  // The doubled vector masked below ptr_i makes the first set bit at or above
  // ptr_i, including wrapped ones in the upper copy, the lowest set bit.
  always_comb begin
    masked = {req_i, req_i} & ({(2*N_REQ){1'b1}} << ptr_i);
    grant_idx_o = '0;
    for (int i = 2*N_REQ-1; i >= 0; i--)
      if (masked[i]) grant_idx_o = IW'(i % N_REQ);
  end
endmodule

// File: rtl/exp_sched.sv
// exp_sched: round-robin scheduler sharing one exp engine among N_REQ requesters
// Ports: clk/rst_n (async active-low); req_valid_i/req_num_i/req_ready_o request
//        side; rsp_valid_o/rsp_data_o/rsp_err_o response side; exp_enable_o/
//        exp_num_o/exp_result_i/exp_data_ready_i engine side; busy_o when not IDLE.
// Build option: EXP_SCHED_TIMEOUT_EN adds a WAIT watchdog that returns a
//        saturated result with rsp_err_o=1 after TIMEOUT cycles.
module exp_sched
  import exp_sched_pkg::*;
#(
  parameter int DATA_WIDTH = EXP_DATA_WIDTH,
  parameter int FIXED_PNT = EXP_FIXED_PNT,
  parameter int N_REQ = 4,
  parameter int MIN_GAP = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_num_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [N_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]       rsp_data_o,
  output logic                        rsp_err_o,
  output logic                        exp_enable_o,
  output logic [DATA_WIDTH-1:0]       exp_num_o,
  input  logic [DATA_WIDTH-1:0]       exp_result_i,
  input  logic                        exp_data_ready_i,
  output logic                        busy_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int GW = $clog2(MIN_GAP + 1);
  if (N_REQ < 2 || N_REQ > 16 || MIN_GAP < 1 || TIMEOUT < 1 || FIXED_PNT >= DATA_WIDTH) begin : g_bad_params
    $error("exp_sched: illegal parameter set");
  end
  sched_state_t state_q;
  logic [IW-1:0] rr_ptr_q, owner_q, grant_idx;
  logic grant_valid;
  logic [GW-1:0] gap_cnt_q;
  logic [DATA_WIDTH-1:0] lane_num [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane_num[g] = req_num_i[g*DATA_WIDTH +: DATA_WIDTH];
  end
  exp_sched_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req_i(req_valid_i),
    .ptr_i(rr_ptr_q),
    .grant_valid_o(grant_valid),
    .grant_idx_o(grant_idx)
  );
  assign busy_o = state_q != IDLE;
`ifdef EXP_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt_q;
  logic rsp_err_q;
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      owner_q <= '0;
      gap_cnt_q <= '0;
      req_ready_o <= '0;
      rsp_valid_o <= '0;
      rsp_data_o <= '0;
      exp_enable_o <= 1'b0;
      exp_num_o <= '0;
`ifdef EXP_SCHED_TIMEOUT_EN
      wd_cnt_q <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      req_ready_o <= '0;
      rsp_valid_o <= '0;
      case (state_q)
        IDLE: if (grant_valid) begin
          req_ready_o <= N_REQ'(1) << grant_idx;
          owner_q <= grant_idx;
          exp_num_o <= lane_num[grant_idx];
          state_q <= ISSUE;
        end
        ISSUE: begin
          exp_enable_o <= 1'b1;
          state_q <= WAIT;
`ifdef EXP_SCHED_TIMEOUT_EN
          wd_cnt_q <= '0;
`endif
        end
        WAIT: if (exp_data_ready_i) begin
          rsp_data_o <= exp_result_i;
          rsp_valid_o <= N_REQ'(1) << owner_q;
          exp_enable_o <= 1'b0;
          state_q <= DONE;
`ifdef EXP_SCHED_TIMEOUT_EN
          rsp_err_q <= 1'b0;
        end else if (wd_cnt_q == TW'(TIMEOUT - 1)) begin
          rsp_data_o <= {1'b0, {(DATA_WIDTH-1){1'b1}}};
          rsp_err_q <= 1'b1;
          rsp_valid_o <= N_REQ'(1) << owner_q;
          exp_enable_o <= 1'b0;
          state_q <= DONE;
        end else begin
          wd_cnt_q <= wd_cnt_q + TW'(1);
`endif
        end
        DONE: begin
          rr_ptr_q <= owner_q == IW'(N_REQ - 1) ? '0 : owner_q + IW'(1);
          gap_cnt_q <= '0;
          state_q <= GAP;
        end
        GAP: begin
          gap_cnt_q <= gap_cnt_q + GW'(1);
          state_q <= gap_cnt_q == GW'(MIN_GAP - 1) ? IDLE : GAP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exp_sched.sv
// tb_exp_sched: scoreboard bench for exp_sched with a latency-configurable engine model
module tb_exp_sched;
  localparam int DW = 16;
  localparam int N = 4;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*DW-1:0] req_num = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [DW-1:0] rsp_data, exp_num, exp_result;
  logic rsp_err, exp_enable, exp_data_ready, busy;
  exp_sched #(.DATA_WIDTH(DW), .FIXED_PNT(8), .N_REQ(N), .MIN_GAP(1), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid_i(req_valid),
    .req_num_i(req_num),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err),
    .exp_enable_o(exp_enable),
    .exp_num_o(exp_num),
    .exp_result_i(exp_result),
    .exp_data_ready_i(exp_data_ready),
    .busy_o(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int lat = 17;
  int stale = 0;
  int ecnt, hold;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt <= 0;
      hold <= 0;
      exp_data_ready <= 1'b0;
      exp_result <= '0;
    end else if (exp_enable) begin
      hold <= stale;
      if (!exp_data_ready) begin
        ecnt <= ecnt + 1;
        if (ecnt + 1 == lat) begin
          exp_data_ready <= 1'b1;
          exp_result <= exp_num + 16'h0100;
        end
      end
    end else begin
      ecnt <= 0;
      if (hold > 0) hold <= hold - 1;
      else exp_data_ready <= 1'b0;
    end
  end
  typedef struct {
    int lane;
    logic [DW-1:0] num;
    logic [DW-1:0] data;
    logic err;
    int lat;
  } exp_t;
  exp_t rq[$];
  int gq[$];
  int checks = 0;
  int failures = 0;
  int gcyc = 0;
  always @(negedge clk) begin : monitor
    int g;
    exp_t e;
    if (rst_n) begin
      if (|req_ready) begin
        checks++;
        gcyc = cyc;
        if (gq.size() == 0) begin
          failures++;
          $display("FAIL grant: req_ready=%b but no grant expected", req_ready);
        end else begin
          g = gq.pop_front();
          if (req_ready !== (N'(1) << g)) begin
            failures++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, N'(1) << g);
          end
        end
      end
      if (|rsp_valid) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL rsp: rsp_valid=%b data=%h but no response expected", rsp_valid, rsp_data);
        end else begin
          e = rq.pop_front();
          if (rsp_valid !== (N'(1) << e.lane) || rsp_data !== e.data || rsp_err !== e.err ||
              exp_num !== e.num || exp_enable !== 1'b0 || cyc - gcyc != e.lat) begin
            failures++;
            $display("FAIL rsp lane%0d: got valid=%b data=%h err=%b num=%h en=%b lat=%0d, expected valid=%b data=%h err=%b num=%h en=0 lat=%0d",
                     e.lane, rsp_valid, rsp_data, rsp_err, exp_num, exp_enable, cyc - gcyc,
                     N'(1) << e.lane, e.data, e.err, e.num, e.lat);
          end
        end
      end
    end
  end
  task automatic expect_rsp(input int lane, input logic [DW-1:0] num, input logic [DW-1:0] data,
                            input logic err, input int l);
    gq.push_back(lane);
    rq.push_back('{lane, num, data, err, l});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (req_ready[i]) req_valid[i] = 1'b0;
  endtask
  task automatic post(input int lane, input logic [DW-1:0] num);
    req_num[lane*DW +: DW] = num;
    req_valid[lane] = 1'b1;
  endtask
  task automatic wait_grant(input int lane);
    int n = 0;
    while (req_valid[lane] && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_grant lane%0d: no req_ready within %0d cycles", lane, n);
    end
  endtask
  task automatic drain(input string name);
    int n = 0;
    while ((rq.size() != 0 || gq.size() != 0 || busy || |req_valid) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL drain %s: pending rsp=%0d grants=%0d busy=%b after %0d cycles, expected all done",
               name, rq.size(), gq.size(), busy, n);
    end
  endtask
  task automatic check_zero(input string name);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, exp_enable, exp_num, busy} !== '0) begin
      failures++;
      $display("FAIL %s: rdy=%b vld=%b data=%h err=%b en=%b num=%h busy=%b, expected all 0",
               name, req_ready, rsp_valid, rsp_data, rsp_err, exp_enable, exp_num, busy);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    expect_rsp(0, 16'h0010, 16'h0110, 1'b0, 19);
    expect_rsp(1, 16'hFF00, 16'h0000, 1'b0, 19);
    expect_rsp(2, 16'h0123, 16'h0223, 1'b0, 19);
    expect_rsp(3, 16'h7F00, 16'h8000, 1'b0, 19);
    expect_rsp(0, 16'h0200, 16'h0300, 1'b0, 19);
    post(0, 16'h0010);
    post(1, 16'hFF00);
    post(2, 16'h0123);
    post(3, 16'h7F00);
    wait_grant(0);
    post(0, 16'h0200);
    drain("rr_all");
    expect_rsp(2, 16'h0000, 16'h0100, 1'b0, 19);
    post(2, 16'h0000);
    drain("single");
    stale = 3;
    expect_rsp(3, 16'h0500, 16'h0600, 1'b0, 19);
    expect_rsp(1, 16'h0040, 16'h0140, 1'b0, 19);
    post(1, 16'h0040);
    post(3, 16'h0500);
    drain("stale");
    stale = 0;
    expect_rsp(0, 16'h0001, 16'h0101, 1'b0, 19);
    post(0, 16'h0001);
    wait_grant(0);
    post(1, 16'h0002);
    post(3, 16'h0003);
    expect_rsp(3, 16'h0003, 16'h0103, 1'b0, 19);
    repeat (3) tick();
    req_valid[1] = 1'b0;
    drain("drop");
    gq.push_back(1);
    post(1, 16'h0777);
    wait_grant(1);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_hold");
    rst_n = 1'b1;
    expect_rsp(3, 16'h0ABC, 16'h0BBC, 1'b0, 19);
    post(3, 16'h0ABC);
    drain("after_reset");
`ifdef EXP_SCHED_TIMEOUT_EN
    lat = 100000;
    expect_rsp(2, 16'h0123, 16'h7FFF, 1'b1, TO + 1);
    post(2, 16'h0123);
    drain("timeout");
    lat = 17;
    expect_rsp(0, 16'h0020, 16'h0120, 1'b0, 19);
    expect_rsp(2, 16'h0030, 16'h0130, 1'b0, 19);
    post(0, 16'h0020);
    post(2, 16'h0030);
    drain("after_timeout");
`endif
    repeat (4) tick();
    checks++;
    if (rq.size() != 0 || gq.size() != 0) begin
      failures++;
      $display("FAIL leftover: rsp=%0d grants=%0d outstanding, expected 0", rq.size(), gq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
